// File: rtl/ddr_bringup_pkg.sv
// rtl/ddr_bringup_pkg.sv - shared types and constants for the DDR bring-up sequencer
package ddr_bringup_pkg;

  localparam int TMR_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_PULSE,
    ST_DONE_WAIT,
    ST_CAL_WAIT,
    ST_TG_WAIT,
    ST_RETRY,
    ST_READY,
    ST_FAIL
  } state_e;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_DONE_TMO = 3'd1;
  localparam logic [2:0] ERR_CAL_FAIL = 3'd2;
  localparam logic [2:0] ERR_CAL_TMO  = 3'd3;
  localparam logic [2:0] ERR_TG_FAIL  = 3'd4;
  localparam logic [2:0] ERR_TG_TMO   = 3'd5;
  localparam logic [2:0] ERR_TG_WDOG  = 3'd6;
  localparam logic [2:0] ERR_LOST     = 3'd7;

  // True on the last cycle of a LIMIT-cycle stay in a timed state.
  function automatic logic tmr_hit(input logic [TMR_W-1:0] t, input int unsigned limit);
    return t == TMR_W'(limit - 1);
  endfunction

endpackage

// File: rtl/ddr_bringup_sync.sv
// rtl/ddr_bringup_sync.sv - N-bit two-stage synchronizer for asynchronous status inputs
module ddr_bringup_sync #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] meta_q;
  logic [N-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ddr_bringup_seq.sv
// rtl/ddr_bringup_seq.sv - EMIF reset/calibration/traffic-gen bring-up FSM with bounded retries
module ddr_bringup_seq #(
  parameter int unsigned RST_PULSE_CYC = 16,
  parameter int unsigned DONE_TMO_CYC  = 4096,
  parameter int unsigned CAL_TMO_CYC   = 32'd1 << 22,
  parameter int unsigned TG_TMO_CYC    = 32'd1 << 24,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       local_reset_req,
  input  logic       local_reset_done,
  input  logic       cal_success,
  input  logic       cal_fail,
  input  logic       tg_pass,
  input  logic       tg_fail,
  input  logic       tg_timeout,
  output logic       busy,
  output logic       ready,
  output logic       error,
  output logic [2:0] err_code,
  output logic [1:0] retry_cnt
);

  import ddr_bringup_pkg::*;

  logic [5:0] in_s;
  logic       done_s, cal_ok_s, cal_fail_s, tg_pass_s, tg_fail_s, tg_tmo_s;

  ddr_bringup_sync #(.N(6)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({tg_timeout, tg_pass, tg_fail, cal_fail, cal_success, local_reset_done}),
    .q     (in_s)
  );

  assign {tg_tmo_s, tg_pass_s, tg_fail_s, cal_fail_s, cal_ok_s, done_s} = in_s;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [2:0]       err_code_q, err_code_d;
  logic [1:0]       retry_cnt_q, retry_cnt_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             error_q, error_d;
  logic             restartable;

  always_comb begin
    state_d     = state_q;
    err_code_d  = err_code_q;
    retry_cnt_d = retry_cnt_q;
    restartable = (state_q == ST_IDLE) || (state_q == ST_READY) || (state_q == ST_FAIL);

    if (start && restartable) begin
      state_d     = ST_RST_PULSE;
      err_code_d  = ERR_NONE;
      retry_cnt_d = 2'd0;
    end else begin
      case (state_q)
        ST_RST_PULSE: begin
          if (tmr_hit(timer_q, RST_PULSE_CYC)) state_d = ST_DONE_WAIT;
        end
        ST_DONE_WAIT: begin
          if (done_s) begin
            state_d = ST_CAL_WAIT;
          end else if (tmr_hit(timer_q, DONE_TMO_CYC)) begin
            state_d    = ST_RETRY;
            err_code_d = ERR_DONE_TMO;
          end
        end
        ST_CAL_WAIT: begin
          if (cal_fail_s) begin
            state_d    = ST_RETRY;
            err_code_d = ERR_CAL_FAIL;
          end else if (cal_ok_s) begin
            state_d = ST_TG_WAIT;
          end else if (tmr_hit(timer_q, CAL_TMO_CYC)) begin
            state_d    = ST_RETRY;
            err_code_d = ERR_CAL_TMO;
          end
        end
        ST_TG_WAIT: begin
          if (tg_fail_s) begin
            state_d    = ST_RETRY;
            err_code_d = ERR_TG_FAIL;
          end else if (tg_tmo_s) begin
            state_d    = ST_RETRY;
            err_code_d = ERR_TG_TMO;
          end else if (tg_pass_s) begin
            state_d = ST_READY;
          end else if (tmr_hit(timer_q, TG_TMO_CYC)) begin
            state_d    = ST_RETRY;
            err_code_d = ERR_TG_WDOG;
          end
        end
        ST_RETRY: begin
          if (32'(retry_cnt_q) < MAX_RETRY) begin
            retry_cnt_d = retry_cnt_q + 2'd1;
            state_d     = ST_RST_PULSE;
          end else begin
            state_d = ST_FAIL;
          end
        end
        ST_READY: begin
          // Losing calibration after READY reuses whatever retries remain.
          if (!cal_ok_s || !done_s) begin
            state_d    = ST_RETRY;
            err_code_d = ERR_LOST;
          end
        end
        default: ;
      endcase
    end

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q != '1) begin
      timer_d = timer_q + TMR_W'(1);
    end else begin
      timer_d = timer_q;
    end

    req_d   = (state_d == ST_RST_PULSE);
    busy_d  = !((state_d == ST_IDLE) || (state_d == ST_READY) || (state_d == ST_FAIL));
    ready_d = (state_d == ST_READY);
    error_d = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      err_code_q  <= ERR_NONE;
      retry_cnt_q <= 2'd0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      err_code_q  <= err_code_d;
      retry_cnt_q <= retry_cnt_d;
      req_q       <= req_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
    end
  end

  assign local_reset_req = req_q;
  assign busy            = busy_q;
  assign ready           = ready_q;
  assign error           = error_q;
  assign err_code        = err_code_q;
  assign retry_cnt       = retry_cnt_q;

endmodule

// File: tb/tb_ddr_bringup_seq.sv
// tb/tb_ddr_bringup_seq.sv - scoreboard bench for ddr_bringup_seq with a scripted EMIF/TG model
module tb_ddr_bringup_seq;

  localparam int DONE_TMO = 64;
  localparam int CAL_TMO  = 200;
  localparam int TG_TMO   = 1000;

  localparam int CAL_NONE = 0, CAL_OK = 1, CAL_BAD = 2, CAL_BOTH = 3;
  localparam int TG_NONE  = 0, TG_PASS = 1, TG_BAD = 2, TG_ALL = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       local_reset_req;
  logic       local_reset_done = 1'b0;
  logic       cal_success = 1'b0;
  logic       cal_fail = 1'b0;
  logic       tg_pass = 1'b0;
  logic       tg_fail = 1'b0;
  logic       tg_timeout = 1'b0;
  logic       busy, ready, error;
  logic [2:0] err_code;
  logic [1:0] retry_cnt;

  typedef struct packed {
    logic       rdy;
    logic       err;
    logic [1:0] rc;
    logic [2:0] ec;
  } exp_t;

  exp_t exp_q[$];
  int   widths[$];
  int   gaps[$];
  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  int   rise_count = 0;
  int   fall_count = 0;
  int   last_rise = 0;
  int   last_fall = 0;
  int   consumed = 0;
  logic req_prev = 1'b0;

  always #5 clk = ~clk;

  ddr_bringup_seq #(
    .RST_PULSE_CYC (16),
    .DONE_TMO_CYC  (DONE_TMO),
    .CAL_TMO_CYC   (CAL_TMO),
    .TG_TMO_CYC    (TG_TMO),
    .MAX_RETRY     (3)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .local_reset_req  (local_reset_req),
    .local_reset_done (local_reset_done),
    .cal_success      (cal_success),
    .cal_fail         (cal_fail),
    .tg_pass          (tg_pass),
    .tg_fail          (tg_fail),
    .tg_timeout       (tg_timeout),
    .busy             (busy),
    .ready            (ready),
    .error            (error),
    .err_code         (err_code),
    .retry_cnt        (retry_cnt)
  );

  // Pulse monitor: width of each request pulse and low gap before each rise.
  always @(negedge clk) begin
    cyc++;
    if (local_reset_req === 1'b1 && !req_prev) begin
      rise_count++;
      gaps.push_back(cyc - last_fall);
      last_rise = cyc;
    end
    if (local_reset_req !== 1'b1 && req_prev) begin
      fall_count++;
      widths.push_back(cyc - last_rise);
      last_fall = cyc;
    end
    req_prev = (local_reset_req === 1'b1);
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic begin_scenario();
    widths.delete();
    gaps.delete();
    consumed = rise_count;
  endtask

  // One EMIF attempt: wait for the next request pulse, then script the status inputs.
  task automatic do_attempt(input int done_dly, input int cal_dly, input int cal_mode,
                            input int tg_dly, input int tg_mode, input bit poke);
    int n;
    n = 0;
    while (rise_count <= consumed && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      fails++;
      $display("FAIL attempt_rise timeout: no request pulse after %0d cycles, want one", n);
      return;
    end
    {local_reset_done, cal_success, cal_fail, tg_pass, tg_fail, tg_timeout} = '0;
    n = 0;
    while (fall_count <= consumed && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      fails++;
      $display("FAIL attempt_fall timeout: request still high after %0d cycles, want low", n);
      return;
    end
    consumed++;
    if (done_dly < 0) return;
    repeat (done_dly) @(negedge clk);
    local_reset_done = 1'b1;
    if (poke) begin
      repeat (5) @(negedge clk);
      pulse_start();
    end
    if (cal_mode == CAL_NONE) return;
    repeat (cal_dly) @(negedge clk);
    cal_success = (cal_mode == CAL_OK) || (cal_mode == CAL_BOTH);
    cal_fail    = (cal_mode == CAL_BAD) || (cal_mode == CAL_BOTH);
    if (cal_mode != CAL_OK || tg_mode == TG_NONE) return;
    repeat (tg_dly) @(negedge clk);
    tg_pass    = (tg_mode == TG_PASS) || (tg_mode == TG_ALL);
    tg_fail    = (tg_mode == TG_BAD) || (tg_mode == TG_ALL);
    tg_timeout = (tg_mode == TG_ALL);
  endtask

  // Scoreboard consumer: wait for a terminal status and compare against the oldest expectation.
  task automatic score_outcome(input string name);
    int   n;
    exp_t e;
    n = 0;
    while (!(ready === 1'b1 || error === 1'b1) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      fails++;
      $display("FAIL %s settle timeout: ready=%b error=%b after %0d cycles", name, ready, error, n);
    end
    if (exp_q.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL %s scoreboard empty", name);
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if (ready !== e.rdy) begin
      fails++;
      $display("FAIL %s ready got %b want %b", name, ready, e.rdy);
    end
    checks++;
    if (error !== e.err) begin
      fails++;
      $display("FAIL %s error got %b want %b", name, error, e.err);
    end
    checks++;
    if (retry_cnt !== e.rc) begin
      fails++;
      $display("FAIL %s retry_cnt got %0d want %0d", name, retry_cnt, e.rc);
    end
    checks++;
    if (err_code !== e.ec) begin
      fails++;
      $display("FAIL %s err_code got %0d want %0d", name, err_code, e.ec);
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s busy got %b want 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (local_reset_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b want 0", local_reset_req); end
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", ready); end
    checks++;
    if (error !== 1'b0) begin fails++; $display("FAIL reset_error got %b want 0", error); end
    checks++;
    if (err_code !== 3'd0) begin fails++; $display("FAIL reset_err_code got %0d want 0", err_code); end
    checks++;
    if (retry_cnt !== 2'd0) begin fails++; $display("FAIL reset_retry_cnt got %0d want 0", retry_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    begin_scenario();
    exp_q.push_back(exp_t'{1'b1, 1'b0, 2'd0, 3'd0});
    pulse_start();
    do_attempt(10, 100, CAL_OK, 500, TG_PASS, 1'b0);
    score_outcome("nominal");
    checks++;
    if (widths.size() != 1 || widths[0] != 16) begin
      fails++;
      $display("FAIL nominal_pulse_width got %0d (pulses %0d) want 16", widths.size() ? widths[0] : -1, widths.size());
    end
  endtask

  task automatic test_cal_recover();
    begin_scenario();
    exp_q.push_back(exp_t'{1'b1, 1'b0, 2'd1, 3'd2});
    pulse_start();
    do_attempt(10, 50, CAL_BAD, 0, TG_NONE, 1'b0);
    do_attempt(10, 50, CAL_OK, 50, TG_PASS, 1'b0);
    score_outcome("cal_recover");
    checks++;
    if (widths.size() != 2 || widths[1] != 16) begin
      fails++;
      $display("FAIL cal_recover_pulses got %0d pulses want 2 of width 16", widths.size());
    end
  endtask

  task automatic test_simul_cal();
    begin_scenario();
    exp_q.push_back(exp_t'{1'b1, 1'b0, 2'd1, 3'd2});
    pulse_start();
    do_attempt(10, 20, CAL_BOTH, 0, TG_NONE, 1'b0);
    do_attempt(10, 20, CAL_OK, 20, TG_PASS, 1'b0);
    score_outcome("simul_cal");
  endtask

  task automatic test_simul_tg();
    begin_scenario();
    exp_q.push_back(exp_t'{1'b1, 1'b0, 2'd1, 3'd4});
    pulse_start();
    do_attempt(10, 20, CAL_OK, 20, TG_ALL, 1'b0);
    do_attempt(10, 20, CAL_OK, 20, TG_PASS, 1'b0);
    score_outcome("simul_tg");
  endtask

  task automatic test_tg_watchdog();
    begin_scenario();
    exp_q.push_back(exp_t'{1'b1, 1'b0, 2'd1, 3'd6});
    pulse_start();
    do_attempt(10, 20, CAL_OK, 0, TG_NONE, 1'b0);
    do_attempt(10, 20, CAL_OK, 20, TG_PASS, 1'b0);
    score_outcome("tg_watchdog");
  endtask

  task automatic test_lost_ready();
    begin_scenario();
    exp_q.push_back(exp_t'{1'b1, 1'b0, 2'd2, 3'd7});
    @(negedge clk);
    cal_success = 1'b0;
    do_attempt(10, 20, CAL_OK, 20, TG_PASS, 1'b0);
    score_outcome("lost_ready");
    checks++;
    if (widths.size() != 1 || widths[0] != 16) begin
      fails++;
      $display("FAIL lost_ready_repulse got %0d pulses want 1 of width 16", widths.size());
    end
  endtask

  task automatic test_start_ignored();
    int base;
    begin_scenario();
    base = rise_count;
    exp_q.push_back(exp_t'{1'b1, 1'b0, 2'd0, 3'd0});
    pulse_start();
    do_attempt(10, 40, CAL_OK, 20, TG_PASS, 1'b1);
    score_outcome("start_ignored");
    checks++;
    if (rise_count - base != 1) begin
      fails++;
      $display("FAIL start_ignored_pulses got %0d want 1", rise_count - base);
    end
  endtask

  task automatic test_persistent_tg_fail();
    int base;
    begin_scenario();
    base = rise_count;
    exp_q.push_back(exp_t'{1'b0, 1'b1, 2'd3, 3'd4});
    pulse_start();
    for (int i = 0; i < 4; i++) do_attempt(10, 20, CAL_OK, 20, TG_BAD, 1'b0);
    score_outcome("persistent_tg_fail");
    repeat (40) @(negedge clk);
    checks++;
    if (rise_count - base != 4 || widths.size() != 4) begin
      fails++;
      $display("FAIL persistent_pulses got %0d want 4", rise_count - base);
    end
    checks++;
    if (widths.size() == 4 && (widths[0] != 16 || widths[3] != 16)) begin
      fails++;
      $display("FAIL persistent_width got %0d/%0d want 16/16", widths[0], widths[3]);
    end
  endtask

  task automatic test_done_timeout();
    begin_scenario();
    exp_q.push_back(exp_t'{1'b0, 1'b1, 2'd3, 3'd1});
    pulse_start();
    for (int i = 0; i < 4; i++) do_attempt(-1, 0, CAL_NONE, 0, TG_NONE, 1'b0);
    score_outcome("done_timeout");
    checks++;
    if (gaps.size() != 4 || gaps[1] != DONE_TMO + 1 || gaps[3] != DONE_TMO + 1) begin
      fails++;
      $display("FAIL done_timeout_gap got %0d (rises %0d) want %0d", gaps.size() > 1 ? gaps[1] : -1, gaps.size(), DONE_TMO + 1);
    end
  endtask

  task automatic test_rst_mid_pulse();
    int n;
    begin_scenario();
    pulse_start();
    n = 0;
    while (rise_count <= consumed && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (local_reset_req !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_req_busy got %b/%b want 0/0", local_reset_req, busy);
    end
    checks++;
    if (ready !== 1'b0 || error !== 1'b0 || err_code !== 3'd0 || retry_cnt !== 2'd0) begin
      fails++;
      $display("FAIL rst_mid_status got rdy=%b err=%b code=%0d rc=%0d want all 0", ready, error, err_code, retry_cnt);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_cal_recover();
    test_simul_cal();
    test_simul_tg();
    test_tg_watchdog();
    test_lost_ready();
    test_start_ignored();
    test_persistent_tg_fail();
    test_done_timeout();
    test_rst_mid_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
